decode_execute_unit: RTL and testbench

// - Decode/execute slice of the 4-stage RV32I integer core: D (decode + regfile read), X (execute), M (result), W (writeback).
// - Integrates instruction decode/control, operand/result datapath with forwarding, and the add/sub unit.
// - Sits between fetch, which supplies d_inst_i, and the regfile; the external logical/shift units return their results into the writeback path.

---
 rtl/proc_pkg.sv | 50 +++++
 rtl/decode_execute_unit_if.sv | 37 +++
 rtl/decode_execute_unit_arith_addsub.sv | 17 +
 rtl/decode_execute_unit.sv | 153 +++++++++++++++
 tb/tb_decode_execute_unit.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_pkg
// Description : Shared opcodes, mux-select enums and decode helpers for the
//               decode/execute slice of the RV32I core.
// Revision    : 1.0
// ============================================================================
package proc_pkg;

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;

    localparam logic [2:0] c_F3_ADDSUB  = 3'b000;
    localparam logic [2:0] c_F3_SLL     = 3'b001;
    localparam logic [2:0] c_F3_SR      = 3'b101;

    typedef enum logic [1:0] {
        ALU_ARITH   = 2'd0,
        ALU_LOGICAL = 2'd1,
        ALU_SHIFT   = 2'd2
    } alu_mux_sel_t;

    typedef enum logic [1:0] {
        OP1_REG   = 2'd0,
        OP1_FWD_M = 2'd1,
        OP1_FWD_W = 2'd2,
        OP1_ZERO  = 2'd3
    } x_op1_mux_sel_t;

    typedef enum logic [1:0] {
        OP2_REG   = 2'd0,
        OP2_FWD_M = 2'd1,
        OP2_FWD_W = 2'd2,
        OP2_IMM   = 2'd3
    } x_op2_mux_sel_t;

    typedef enum logic {
        W_ALU = 1'b0,
        W_MEM = 1'b1
    } w_mux_sel_t;

    function automatic alu_mux_sel_t alu_sel_from_funct3(input logic [2:0] funct3);
        if (funct3 == c_F3_ADDSUB) return ALU_ARITH;
        if (funct3 == c_F3_SLL || funct3 == c_F3_SR) return ALU_SHIFT;
        return ALU_LOGICAL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_execute_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_execute_unit_if
// Description : Fetch / regfile / external-unit bus of the decode/execute slice.
// Revision    : 1.0
// ============================================================================
interface decode_execute_unit_if #(
    parameter int XLEN = 32
);
    logic [31:0]     d_inst_i;
    logic [4:0]      reg1_addr_o;
    logic [4:0]      reg2_addr_o;
    logic [XLEN-1:0] reg1_data_i;
    logic [XLEN-1:0] reg2_data_i;
    logic [XLEN-1:0] logical_out_i;
    logic [XLEN-1:0] shift_out_i;
    logic [XLEN-1:0] x_op1_o;
    logic [XLEN-1:0] x_op2_o;
    logic [2:0]      x_funct3_o;
    logic            x_funct7_30_o;
    logic [XLEN-1:0] m_alu_data_o;
    logic [XLEN-1:0] w_mux_o;
    logic [4:0]      reg_w_addr_o;

    modport master (
        input  d_inst_i, reg1_data_i, reg2_data_i, logical_out_i, shift_out_i,
        output reg1_addr_o, reg2_addr_o, x_op1_o, x_op2_o, x_funct3_o,
               x_funct7_30_o, m_alu_data_o, w_mux_o, reg_w_addr_o
    );

    modport slave (
        output d_inst_i, reg1_data_i, reg2_data_i, logical_out_i, shift_out_i,
        input  reg1_addr_o, reg2_addr_o, x_op1_o, x_op2_o, x_funct3_o,
               x_funct7_30_o, m_alu_data_o, w_mux_o, reg_w_addr_o
    );
endinterface
`default_nettype wire

// File: rtl/decode_execute_unit_arith_addsub.sv
`default_nettype none
// ============================================================================
// Module      : arith_addsub
// Description : Combinational wrap-around adder/subtractor (i_funct=1 -> sub).
// Revision    : 1.0
// ============================================================================
module arith_addsub #(
    parameter int XLEN = 32
) (
    input  logic            i_funct,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    output logic [XLEN-1:0] o_res
);
    assign o_res = i_funct ? (i_op1 - i_op2) : (i_op1 + i_op2);
endmodule
`default_nettype wire

// File: rtl/decode_execute_unit.sv
`default_nettype none
// ============================================================================
// Module      : decode_execute_unit
// Description : D/X/M/W decode-execute slice with operand forwarding.
// Revision    : 1.0
// ============================================================================
module decode_execute_unit
    import proc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    decode_execute_unit_if.master bus
);
    localparam w_mux_sel_t c_W_SEL = W_ALU;

    logic [31:0]     w_inst;
    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic            w_is_op, w_is_op_imm, w_is_lui, w_is_shift;
    logic [4:0]      w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0] w_imm;
    x_op1_mux_sel_t  w_op1_sel;
    x_op2_mux_sel_t  w_op2_sel;
    alu_mux_sel_t    w_alu_sel;
    logic            w_sub, w_f7_30;
    logic [2:0]      w_funct3;

    x_op1_mux_sel_t  r_x_op1_sel;
    x_op2_mux_sel_t  r_x_op2_sel;
    alu_mux_sel_t    r_x_alu_sel;
    logic [XLEN-1:0] r_x_rs1_data, r_x_rs2_data, r_x_imm;
    logic            r_x_sub, r_x_f7_30;
    logic [2:0]      r_x_funct3;
    logic [4:0]      r_x_rd;
    logic [XLEN-1:0] r_m_data;
    logic [4:0]      r_m_rd;
    logic [XLEN-1:0] r_w_data;

    logic [XLEN-1:0] w_x_op1, w_x_op2, w_arith_res, w_x_res;

    assign w_inst   = bus.d_inst_i;
    assign w_opcode = w_inst[6:0];
    assign w_f3     = w_inst[14:12];
    assign w_rs1    = w_inst[19:15];
    assign w_rs2    = w_inst[24:20];

    assign bus.reg1_addr_o = w_rs1;
    assign bus.reg2_addr_o = w_rs2;

    // Forwarding is resolved in D against the instructions now in X (distance 1)
    // and M (distance 2); older results are already in the regfile.
    always_comb begin
        w_is_op     = (w_opcode == c_OPC_OP);
        w_is_op_imm = (w_opcode == c_OPC_OP_IMM);
        w_is_lui    = (w_opcode == c_OPC_LUI);
        w_is_shift  = w_is_op_imm && (w_f3 == c_F3_SLL || w_f3 == c_F3_SR);
        w_rd        = (w_is_op || w_is_op_imm || w_is_lui) ? w_inst[11:7] : 5'd0;

        w_op1_sel = OP1_REG;
        if (w_is_lui)                              w_op1_sel = OP1_ZERO;
        else if (w_rs1 != 5'd0 && w_rs1 == r_x_rd) w_op1_sel = OP1_FWD_M;
        else if (w_rs1 != 5'd0 && w_rs1 == r_m_rd) w_op1_sel = OP1_FWD_W;

        w_op2_sel = OP2_REG;
        if (w_is_op_imm || w_is_lui)               w_op2_sel = OP2_IMM;
        else if (w_rs2 != 5'd0 && w_rs2 == r_x_rd) w_op2_sel = OP2_FWD_M;
        else if (w_rs2 != 5'd0 && w_rs2 == r_m_rd) w_op2_sel = OP2_FWD_W;

        w_imm     = w_is_lui ? XLEN'($signed({w_inst[31:12], 12'h000}))
                             : XLEN'($signed(w_inst[31:20]));
        w_alu_sel = w_is_lui ? ALU_ARITH : alu_sel_from_funct3(w_f3);
        w_sub     = w_is_op && (w_f3 == c_F3_ADDSUB) && w_inst[30];
        w_f7_30   = (w_is_op || w_is_shift) ? w_inst[30] : 1'b0;
        w_funct3  = (w_is_op || w_is_op_imm) ? w_f3 : 3'd0;
    end

    always_comb begin
        w_x_op1 = '0;
        case (r_x_op1_sel)
            OP1_REG:   w_x_op1 = r_x_rs1_data;
            OP1_FWD_M: w_x_op1 = r_m_data;
            OP1_FWD_W: w_x_op1 = r_w_data;
            default:   w_x_op1 = '0;
        endcase

        w_x_op2 = '0;
        case (r_x_op2_sel)
            OP2_REG:   w_x_op2 = r_x_rs2_data;
            OP2_FWD_M: w_x_op2 = r_m_data;
            OP2_FWD_W: w_x_op2 = r_w_data;
            default:   w_x_op2 = r_x_imm;
        endcase

        w_x_res = '0;
        case (r_x_alu_sel)
            ALU_ARITH:   w_x_res = w_arith_res;
            ALU_LOGICAL: w_x_res = bus.logical_out_i;
            ALU_SHIFT:   w_x_res = bus.shift_out_i;
            default:     w_x_res = '0;
        endcase
    end

    arith_addsub #(.XLEN(XLEN)) u_arith_addsub (
        .i_funct (r_x_sub),
        .i_op1   (w_x_op1),
        .i_op2   (w_x_op2),
        .o_res   (w_arith_res)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_x_op1_sel  <= OP1_REG;
            r_x_op2_sel  <= OP2_REG;
            r_x_alu_sel  <= ALU_ARITH;
            r_x_rs1_data <= '0;
            r_x_rs2_data <= '0;
            r_x_imm      <= '0;
            r_x_sub      <= 1'b0;
            r_x_f7_30    <= 1'b0;
            r_x_funct3   <= 3'd0;
            r_x_rd       <= 5'd0;
            r_m_data     <= '0;
            r_m_rd       <= 5'd0;
            r_w_data     <= '0;
        end else begin
            r_x_op1_sel  <= w_op1_sel;
            r_x_op2_sel  <= w_op2_sel;
            r_x_alu_sel  <= w_alu_sel;
            r_x_rs1_data <= bus.reg1_data_i;
            r_x_rs2_data <= bus.reg2_data_i;
            r_x_imm      <= w_imm;
            r_x_sub      <= w_sub;
            r_x_f7_30    <= w_f7_30;
            r_x_funct3   <= w_funct3;
            r_x_rd       <= w_rd;
            r_m_data     <= w_x_res;
            r_m_rd       <= r_x_rd;
            r_w_data     <= r_m_data;
        end
    end

    assign bus.x_op1_o       = w_x_op1;
    assign bus.x_op2_o       = w_x_op2;
    assign bus.x_funct3_o    = r_x_funct3;
    assign bus.x_funct7_30_o = r_x_f7_30;
    assign bus.m_alu_data_o  = r_m_data;
    assign bus.w_mux_o       = (c_W_SEL == W_ALU) ? r_m_data : '0;
    assign bus.reg_w_addr_o  = r_m_rd;

endmodule
`default_nettype wire

// File: tb/tb_decode_execute_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_execute_unit
// Description : Randomized bench with an architectural reference model.
// Revision    : 1.0
// ============================================================================
module tb_decode_execute_unit;

    localparam int          XLEN    = 32;
    localparam logic [6:0]  OPC_R   = 7'b0110011;
    localparam logic [6:0]  OPC_I   = 7'b0010011;
    localparam logic [6:0]  OPC_U   = 7'b0110111;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] res;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  f3;
        logic        f7;
        bit          chk_ops;
        bit          chk_f3;
    } exp_t;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b1;

    decode_execute_unit_if #(.XLEN(XLEN)) bus ();
    decode_execute_unit #(.XLEN(XLEN)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    // Environment: regfile written from the DUT write port, plus the external units.
    logic [31:0] rf [32] = '{default: 32'h0};
    always @(posedge clk_i) if (bus.reg_w_addr_o != 5'd0) rf[bus.reg_w_addr_o] <= bus.w_mux_o;

    always_comb begin
        bus.reg1_data_i = rf[bus.reg1_addr_o];
        bus.reg2_data_i = rf[bus.reg2_addr_o];
        case (bus.x_funct3_o)
            3'b010:  bus.logical_out_i = {31'd0, $signed(bus.x_op1_o) < $signed(bus.x_op2_o)};
            3'b011:  bus.logical_out_i = {31'd0, bus.x_op1_o < bus.x_op2_o};
            3'b100:  bus.logical_out_i = bus.x_op1_o ^ bus.x_op2_o;
            3'b110:  bus.logical_out_i = bus.x_op1_o | bus.x_op2_o;
            3'b111:  bus.logical_out_i = bus.x_op1_o & bus.x_op2_o;
            default: bus.logical_out_i = 32'h0;
        endcase
        if (bus.x_funct3_o == 3'b001)
            bus.shift_out_i = bus.x_op1_o << bus.x_op2_o[4:0];
        else if (bus.x_funct7_30_o)
            bus.shift_out_i = 32'($signed(bus.x_op1_o) >>> bus.x_op2_o[4:0]);
        else
            bus.shift_out_i = bus.x_op1_o >> bus.x_op2_o[4:0];
    end

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] regs   [32];   // architectural state in program order
    logic [31:0] c_regs [32];   // state actually written to the regfile
    exp_t        pipe   [4];    // [k] = instruction issued k cycles ago
    logic [31:0] last_inst;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic exp_t bubble();
        exp_t e;
        e.rd = 5'd0; e.res = 32'h0; e.op1 = 32'h0; e.op2 = 32'h0;
        e.f3 = 3'd0; e.f7 = 1'b0; e.chk_ops = 1'b0; e.chk_f3 = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic i30,
                                            input logic is_reg, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        sa = int'(b[4:0]);
        case (f3)
            3'd0: return (is_reg && i30) ? a - b : a + b;
            3'd1: return a << sa;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return i30 ? 32'($signed(a) >>> sa) : a >> sa;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic issue(input logic [31:0] inst, output exp_t e);
        logic [2:0]  f3;
        logic        i30;
        logic [31:0] a;
        f3  = inst[14:12];
        i30 = inst[30];
        a   = regs[inst[19:15]];
        e   = bubble();
        case (inst[6:0])
            OPC_R: begin
                e.op1 = a; e.op2 = regs[inst[24:20]];
                e.res = ref_alu(f3, i30, 1'b1, e.op1, e.op2);
                e.f7 = i30; e.f3 = f3; e.chk_f3 = 1'b1; e.chk_ops = 1'b1; e.rd = inst[11:7];
            end
            OPC_I: begin
                e.op1 = a; e.op2 = 32'($signed(inst[31:20]));
                e.res = ref_alu(f3, i30, 1'b0, e.op1, e.op2);
                e.f7 = (f3 == 3'd1 || f3 == 3'd5) ? i30 : 1'b0;
                e.f3 = f3; e.chk_f3 = 1'b1; e.chk_ops = 1'b1; e.rd = inst[11:7];
            end
            OPC_U: begin
                e.op1 = 32'h0; e.op2 = {inst[31:12], 12'h000}; e.res = e.op2;
                e.chk_ops = 1'b1; e.rd = inst[11:7];
            end
            default: ;
        endcase
        if (e.rd != 5'd0) regs[e.rd] = e.res;
    endtask

    // One cycle: commit/check older instructions, then present the next one in D.
    task automatic step(input logic [31:0] inst);
        exp_t e;
        @(negedge clk_i);
        for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
        if (pipe[3].rd != 5'd0) c_regs[pipe[3].rd] = pipe[3].res;
        check_val("w_addr", 32'(bus.reg_w_addr_o), 32'(pipe[2].rd));
        if (pipe[2].rd != 5'd0) begin
            check_val("m_alu", bus.m_alu_data_o, pipe[2].res);
            check_val("w_mux", bus.w_mux_o, pipe[2].res);
        end
        if (pipe[1].chk_ops) begin
            check_val("x_op1", bus.x_op1_o, pipe[1].op1);
            check_val("x_op2", bus.x_op2_o, pipe[1].op2);
        end
        if (pipe[1].chk_f3) check_val("x_funct3", 32'(bus.x_funct3_o), 32'(pipe[1].f3));
        check_val("x_f7_30", 32'(bus.x_funct7_30_o), 32'(pipe[1].f7));
        issue(inst, e);
        pipe[0]        = e;
        last_inst      = inst;
        bus.d_inst_i   = inst;
    endtask

    task automatic check_reset_outputs(input logic [31:0] inst);
        check_val("rst_w_addr", 32'(bus.reg_w_addr_o), 32'h0);
        check_val("rst_m_alu",  bus.m_alu_data_o, 32'h0);
        check_val("rst_x_op1",  bus.x_op1_o, 32'h0);
        check_val("rst_x_op2",  bus.x_op2_o, 32'h0);
        check_val("rst_funct3", 32'(bus.x_funct3_o), 32'h0);
        check_val("rst_f7_30",  32'(bus.x_funct7_30_o), 32'h0);
        check_val("rst_rs1",    32'(bus.reg1_addr_o), 32'(inst[19:15]));
        check_val("rst_rs2",    32'(bus.reg2_addr_o), 32'(inst[24:20]));
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        int          kind;
        r    = $urandom;
        rd   = 5'($urandom_range(0, 7));
        rs1  = 5'($urandom_range(0, 7));
        rs2  = 5'($urandom_range(0, 7));
        f3   = 3'($urandom_range(0, 7));
        imm  = r[31:20];
        kind = $urandom_range(0, 9);
        if (kind <= 3) begin
            return {((f3 == 3'd0 || f3 == 3'd5) && r[0]) ? 7'h20 : 7'h00,
                    rs2, rs1, f3, rd, OPC_R};
        end else if (kind <= 7) begin
            if (f3 == 3'd1) imm[11:5] = 7'h00;
            if (f3 == 3'd5) imm[11:5] = r[0] ? 7'h20 : 7'h00;
            return {imm, rs1, f3, rd, OPC_I};
        end else if (kind == 8) begin
            return {r[31:12], rd, OPC_U};
        end
        return {r[31:12], rd, r[1] ? 7'b0000011 : 7'b1100011};
    endfunction

    task automatic mid_reset();
        #2 rst_n_i = 1'b0;
        #1 check_reset_outputs(last_inst);
        for (int i = 0; i < 32; i++) regs[i] = c_regs[i];
        for (int i = 0; i < 4; i++) pipe[i] = bubble();
        step(rand_inst());
        regs = c_regs;
        pipe[0] = bubble();
        step(NOP);
        rst_n_i = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] inst;
        for (int i = 0; i < 32; i++) begin regs[i] = 32'h0; c_regs[i] = 32'h0; end
        for (int i = 0; i < 4; i++) pipe[i] = bubble();
        bus.d_inst_i = NOP;
        last_inst    = NOP;
        #1 rst_n_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            inst = $urandom;
            bus.d_inst_i = inst;
            #1 check_reset_outputs(inst);
        end
        step(NOP);
        rst_n_i = 1'b1;

        step(NOP);
        step(32'h0050_0093);            // ADDI x1,x0,5
        step(32'h0030_8113);            // ADDI x2,x1,3
        step(32'h4011_01B3);            // SUB  x3,x2,x1
        step(32'h1234_5237);            // LUI  x4,0x12345
        step(32'hFFF0_0093);            // ADDI x1,x0,-1
        step(32'h0010_8093);            // ADDI x1,x1,1 -> wraps to 0
        step(32'h0070_0013);            // ADDI x0,x0,7 -> discarded
        step(32'h0010_0313);            // ADDI x6,x0,1
        step(32'h0000_03B3);            // ADD  x7,x0,x0
        for (int i = 0; i < 4; i++) step(NOP);
        check_val("addi_x1", c_regs[1], 32'h0);
        check_val("sub_x3",  c_regs[3], 32'h3);
        check_val("lui_x4",  c_regs[4], 32'h1234_5000);

        for (int i = 0; i < 400; i++) step(rand_inst());
        mid_reset();
        for (int i = 0; i < 200; i++) step(rand_inst());
        for (int i = 0; i < 4; i++) step(NOP);

        for (int i = 1; i < 8; i++) check_val("rf_final", rf[i], c_regs[i]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
